bcd_updown_counter: RTL

- Parametrised multi-digit BCD up/down counter. Successor to the single-digit BCD counters; used for score, lap and timer displays on the ice40 board.
- Counts rising edges of slow increment/decrement requests, or single-cycle strobes.
- Supports synchronous clear, parallel load with digit validation, and wrap or saturate at the range limits.
- Drives the 7-segment/VGA digit renderers through the packed val bus.

---
 rtl/bcd_pkg.sv | 12 +
 rtl/bcd_digit_stage.sv | 35 +++
 rtl/bcd_updown_counter.sv | 114 +++++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared BCD constants and digit helpers for the up/down counter
package bcd_pkg;

   localparam logic [3:0] BCD_MAX    = 4'd9;
   localparam logic [3:0] BCD_ZERO   = 4'd0;
   localparam int         SYNC_DEPTH = 2;

   function automatic logic bcd_valid(input logic [3:0] digit);
      return digit <= BCD_MAX;
   endfunction

endpackage

// File: rtl/bcd_digit_stage.sv
// rtl/bcd_digit_stage.sv - one BCD digit register with clear, load and +/-1 advance
module bcd_digit_stage (
   input  logic       clk,
   input  logic       reset,
   input  logic       up,
   input  logic       dn,
   input  logic       cin,
   input  logic       clr,
   input  logic       ld,
   input  logic [3:0] ld_digit,
   output logic [3:0] digit,
   output logic       at_max,
   output logic       at_min
);
   import bcd_pkg::*;

   assign at_max = (digit == BCD_MAX);
   assign at_min = (digit == BCD_ZERO);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         digit <= BCD_ZERO;
      end else if (clr) begin
         digit <= BCD_ZERO;
      end else if (ld) begin
         // out-of-range load digits are forced to zero so the digit never leaves 0..9
         digit <= bcd_valid(ld_digit) ? ld_digit : BCD_ZERO;
      end else if (cin && up) begin
         digit <= at_max ? BCD_ZERO : digit + 4'd1;
      end else if (cin && dn) begin
         digit <= at_min ? BCD_MAX : digit - 4'd1;
      end
   end

endmodule

// File: rtl/bcd_updown_counter.sv
// rtl/bcd_updown_counter.sv - multi-digit BCD up/down counter with load, clear and wrap/saturate
module bcd_updown_counter #(
   parameter int DIGITS   = 4,
   parameter bit SATURATE = 1'b0,
   parameter bit SYNC_IN  = 1'b1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                en,
   input  logic                inc,
   input  logic                dec,
   input  logic                clr,
   input  logic                load,
   input  logic [4*DIGITS-1:0] load_val,
   output logic [4*DIGITS-1:0] val,
   output logic                carry,
   output logic                borrow,
   output logic                load_err,
   output logic                is_zero
);
   import bcd_pkg::*;

   logic inc_evt;
   logic dec_evt;

   generate
      if (SYNC_IN) begin : g_sync
         // bits [SYNC_DEPTH-1:0] synchronise, the top bit remembers the previous level
         logic [SYNC_DEPTH:0] inc_sh;
         logic [SYNC_DEPTH:0] dec_sh;

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               inc_sh <= '0;
               dec_sh <= '0;
            end else begin
               inc_sh <= {inc_sh[SYNC_DEPTH-1:0], inc};
               dec_sh <= {dec_sh[SYNC_DEPTH-1:0], dec};
            end
         end

         assign inc_evt = inc_sh[SYNC_DEPTH-1] & ~inc_sh[SYNC_DEPTH];
         assign dec_evt = dec_sh[SYNC_DEPTH-1] & ~dec_sh[SYNC_DEPTH];
      end else begin : g_direct
         assign inc_evt = inc;
         assign dec_evt = dec;
      end
   endgenerate

   logic [DIGITS-1:0] at_max;
   logic [DIGITS-1:0] at_min;
   logic [DIGITS-1:0] bad_digit;
   logic [DIGITS-1:0] cin;
   logic [DIGITS:0]   up_chain;
   logic [DIGITS:0]   dn_chain;
   logic              count_ok;
   logic              count_up;
   logic              count_dn;
   logic              all_max;
   logic              all_min;
   logic              hold_up;
   logic              hold_dn;

   assign count_ok = en & (inc_evt ^ dec_evt) & ~clr & ~load;
   assign count_up = count_ok & inc_evt;
   assign count_dn = count_ok & dec_evt;

   assign up_chain[0] = 1'b1;
   assign dn_chain[0] = 1'b1;
   assign all_max     = up_chain[DIGITS];
   assign all_min     = dn_chain[DIGITS];
   // saturation freezes every digit at the limit; the pulse still fires
   assign hold_up     = SATURATE & all_max;
   assign hold_dn     = SATURATE & all_min;

   generate
      for (genvar i = 0; i < DIGITS; i++) begin : g_digit
         assign up_chain[i+1] = up_chain[i] & at_max[i];
         assign dn_chain[i+1] = dn_chain[i] & at_min[i];
         assign bad_digit[i]  = ~bcd_valid(load_val[4*i +: 4]);
         assign cin[i] = (count_up & up_chain[i] & ~hold_up) |
                         (count_dn & dn_chain[i] & ~hold_dn);

         bcd_digit_stage u_stage (
            .clk      (clk),
            .reset    (reset),
            .up       (count_up),
            .dn       (count_dn),
            .cin      (cin[i]),
            .clr      (clr),
            .ld       (load),
            .ld_digit (load_val[4*i +: 4]),
            .digit    (val[4*i +: 4]),
            .at_max   (at_max[i]),
            .at_min   (at_min[i])
         );
      end
   endgenerate

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         carry    <= 1'b0;
         borrow   <= 1'b0;
         load_err <= 1'b0;
      end else begin
         carry    <= count_up & all_max;
         borrow   <= count_dn & all_min;
         load_err <= load & ~clr & (|bad_digit);
      end
   end

   assign is_zero = (val == '0);

endmodule
